dl_sdram_writer: RTL and testbench

- Sits between the data_io ROM download stream (ioctl_*) and one toggle-handshake write port of the sdram controller.
- Replaces the bare edge-detect/toggle logic with a buffered writer: edge-detects ioctl_wr, queues writes in a small FIFO, drives the req/ack toggle handshake and back-pressures the download.
- Generates the rom_loaded qualifier that releases core reset only after every byte has actually reached SDRAM.

---
 rtl/dl_sdram_writer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_dl_sdram_writer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_sdram_writer.sv
// dl_sdram_writer
// Buffered bridge from the data_io ROM download stream to one toggle-handshake
// write port of the sdram controller. Rising edges of ioctl_wr are turned into
// FIFO entries. Entries are issued one at a time with a req/ack toggle
// handshake. When the FIFO nears full, ioctl_wait holds off the download.
// rom_loaded goes high only after the download has ended and every queued
// byte has been acknowledged by the sdram.
//
// Optional feature macro: DL_WORD_PACK_EN
//   When defined, an even byte and the odd byte that follows it at the same
//   word address are merged into one 16-bit write.
//
// Ports
//   clk_sys      in   system clock
//   reset_n      in   synchronous active-low reset
//   ioctl_downl  in   download in progress
//   ioctl_wr     in   byte-write strobe (level, edge-detected here)
//   ioctl_addr   in   byte address [24:0]
//   ioctl_dout   in   byte data
//   ioctl_wait   out  back-pressure to the download source
//   port_req     out  toggle request to sdram
//   port_ack     in   toggle acknowledge from sdram
//   port_a       out  word address
//   port_ds      out  byte enables {hi,lo}
//   port_d       out  write data
//   port_we      out  high while a request is outstanding
//   rom_loaded   out  sticky: download finished and FIFO drained
//   overflow     out  sticky: a write was dropped on a full FIFO
module dl_sdram_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 23
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_downl,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic              port_req,
    input  logic              port_ack,
    output logic [ADDR_W-1:0] port_a,
    output logic [1:0]        port_ds,
    output logic [15:0]       port_d,
    output logic              port_we,
    output logic              rom_loaded,
    output logic              overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic              r_wr_last;
    logic [PW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_mem_a [FIFO_DEPTH];
    logic [1:0]        r_mem_ds[FIFO_DEPTH];
    logic [15:0]       r_mem_d [FIFO_DEPTH];
    logic              r_req, r_we, r_wait, r_rom_loaded, r_overflow;
    logic [ADDR_W-1:0] r_a;
    logic [1:0]        r_ds;
    logic [15:0]       r_d;

    logic              w_accept, w_issue_en, w_flush_en, w_enter_load, w_enter_done;
    logic              w_wr_evt, w_full, w_drained, w_issue, w_pop;
    logic              w_want, w_push, w_drop;
    logic [ADDR_W-1:0] w_byte_a, w_pa;
    logic [1:0]        w_pds;
    logic [15:0]       w_pd;
    logic              w_unused_addr;

`ifdef DL_WORD_PACK_EN
    logic              r_lat_vld;
    logic [ADDR_W-1:0] r_lat_a;
    logic [7:0]        r_lat_d;
    logic              w_lat_set, w_lat_clr;
`endif

    assign w_byte_a      = ioctl_addr[ADDR_W:1];
    assign w_unused_addr = &{1'b0, ioctl_addr[24]};
    assign w_wr_evt      = ioctl_wr & ~r_wr_last & ioctl_downl & w_accept;
    assign w_full        = (r_count == CW'(FIFO_DEPTH));
    // A request is outstanding from issue until the ack toggle is observed.
    assign w_pop         = r_we & (port_ack == r_req);
    assign w_issue       = w_issue_en & (r_count != CW'(0)) & ~r_we & (port_ack == r_req);
`ifdef DL_WORD_PACK_EN
    assign w_drained     = (r_count == CW'(0)) & ~r_we & ~r_lat_vld;
`else
    assign w_drained     = (r_count == CW'(0)) & ~r_we;
`endif

    // FSM state register
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = ioctl_downl ? S_LOAD  : S_IDLE;
            S_LOAD:  w_state_nxt = ioctl_downl ? S_LOAD  : S_DRAIN;
            S_DRAIN: w_state_nxt = w_drained   ? S_DONE  : S_DRAIN;
            S_DONE:  w_state_nxt = ioctl_downl ? S_LOAD  : S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM control outputs
    always_comb begin
        w_accept     = (r_state == S_LOAD);
        w_issue_en   = (r_state == S_LOAD) | (r_state == S_DRAIN);
        w_flush_en   = (r_state == S_DRAIN);
        w_enter_load = (w_state_nxt == S_LOAD) & (r_state != S_LOAD);
        w_enter_done = (w_state_nxt == S_DONE) & (r_state == S_DRAIN);
    end

    // Select what (if anything) is pushed into the FIFO this cycle
    always_comb begin
        w_want = 1'b0;
        w_pa   = '0;
        w_pds  = 2'b00;
        w_pd   = 16'h0000;
`ifdef DL_WORD_PACK_EN
        w_lat_set = 1'b0;
        w_lat_clr = 1'b0;
        if (w_wr_evt) begin
            if (ioctl_addr[0] == 1'b0) begin
                // Even byte is held; a previously held byte goes out alone.
                w_lat_set = 1'b1;
                if (r_lat_vld) begin
                    w_want = 1'b1;
                    w_pa   = r_lat_a;
                    w_pds  = 2'b01;
                    w_pd   = {r_lat_d, r_lat_d};
                end else begin
                    w_want = 1'b0;
                end
            end else begin
                if (r_lat_vld && (r_lat_a == w_byte_a)) begin
                    w_want    = 1'b1;
                    w_pa      = w_byte_a;
                    w_pds     = 2'b11;
                    w_pd      = {ioctl_dout, r_lat_d};
                    w_lat_clr = 1'b1;
                end else begin
                    w_want = 1'b1;
                    w_pa   = w_byte_a;
                    w_pds  = 2'b10;
                    w_pd   = {ioctl_dout, ioctl_dout};
                end
            end
        end else if (w_flush_en && r_lat_vld && !w_full) begin
            // Flush a stranded even byte once the download has ended.
            w_want    = 1'b1;
            w_pa      = r_lat_a;
            w_pds     = 2'b01;
            w_pd      = {r_lat_d, r_lat_d};
            w_lat_clr = 1'b1;
        end else begin
            w_want = 1'b0;
        end
`else
        if (w_wr_evt) begin
            w_want = 1'b1;
            w_pa   = w_byte_a;
            w_pds  = {ioctl_addr[0], ~ioctl_addr[0]};
            w_pd   = {ioctl_dout, ioctl_dout};
        end else begin
            w_want = 1'b0;
        end
`endif
        w_push = w_want & ~w_full;
        w_drop = w_want & w_full;
    end

`ifdef DL_WORD_PACK_EN
    // Low-byte latch for word packing
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_lat_vld <= 1'b0;
            r_lat_a   <= '0;
            r_lat_d   <= 8'h00;
        end else if (w_lat_set) begin
            r_lat_vld <= 1'b1;
            r_lat_a   <= w_byte_a;
            r_lat_d   <= ioctl_dout;
        end else if (w_lat_clr) begin
            r_lat_vld <= 1'b0;
        end
    end
`endif

    // FIFO storage; contents are don't-care while the count is zero
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_mem_a[r_wptr]  <= w_pa;
            r_mem_ds[r_wptr] <= w_pds;
            r_mem_d[r_wptr]  <= w_pd;
        end
    end

    // FIFO pointers, handshake and status flags
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_wr_last    <= 1'b0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_req        <= port_ack;
            r_we         <= 1'b0;
            r_a          <= '0;
            r_ds         <= 2'b00;
            r_d          <= 16'h0000;
            r_wait       <= 1'b0;
            r_rom_loaded <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_wr_last <= ioctl_wr;
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_issue) begin
                r_a   <= r_mem_a[r_rptr];
                r_ds  <= r_mem_ds[r_rptr];
                r_d   <= r_mem_d[r_rptr];
                r_req <= ~r_req;
                r_we  <= 1'b1;
            end else if (w_pop) begin
                r_we <= 1'b0;
            end else if (!r_we && (port_ack != r_req)) begin
                // Stray ack with nothing outstanding: realign, never pop.
                r_req <= port_ack;
            end
            // Registered, so one spare slot covers the lag.
            r_wait <= (r_count >= CW'(FIFO_DEPTH - 1));
            if (w_enter_load) begin
                r_rom_loaded <= 1'b0;
                r_overflow   <= 1'b0;
            end else begin
                if (w_enter_done) begin
                    r_rom_loaded <= 1'b1;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign ioctl_wait = r_wait;
    assign port_req   = r_req;
    assign port_we    = r_we;
    assign port_a     = r_a;
    assign port_ds    = r_ds;
    assign port_d     = r_d;
    assign rom_loaded = r_rom_loaded;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_dl_sdram_writer.sv
// Testbench for dl_sdram_writer: directed byte downloads against an sdram
// ack responder; a monitor records every issued request for comparison.
module tb_dl_sdram_writer;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_downl;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        port_req;
    logic        port_ack;
    logic [22:0] port_a;
    logic [1:0]  port_ds;
    logic [15:0] port_d;
    logic        port_we;
    logic        rom_loaded;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;

    logic        ack_auto  = 1'b0;
    int          stray_cnt = 0;
    logic [40:0] cap[$];

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic [22:0] ea;
        logic [1:0]  eds;
        logic [15:0] ed;
    } vec_t;
    vec_t vec[8];

    dl_sdram_writer #(.FIFO_DEPTH(4), .ADDR_W(23)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_downl (ioctl_downl),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_wait  (ioctl_wait),
        .port_req    (port_req),
        .port_ack    (port_ack),
        .port_a      (port_a),
        .port_ds     (port_ds),
        .port_d      (port_d),
        .port_we     (port_we),
        .rom_loaded  (rom_loaded),
        .overflow    (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    // sdram model: returns ack 3 cycles after a req toggle; can inject a stray toggle
    initial begin
        int dly;
        int stray_done;
        dly        = 0;
        stray_done = 0;
        port_ack   = 1'b1;
        forever begin
            @(negedge clk_sys);
            if (stray_cnt > stray_done) begin
                port_ack   = ~port_ack;
                stray_done = stray_done + 1;
            end else if (ack_auto && (port_req !== port_ack)) begin
                dly = dly + 1;
                if (dly >= 3) begin
                    port_ack = port_req;
                    dly      = 0;
                end
            end else begin
                dly = 0;
            end
        end
    end

    // Request monitor: records {a, ds, d} whenever req toggles with we high
    initial begin
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (port_req !== prev_req) begin
                if (port_we === 1'b1) begin
                    cap.push_back({port_a, port_ds, port_d});
                end
                prev_req = port_req;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input int hold);
        @(negedge clk_sys);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        repeat (hold) @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_loaded(input int max_cyc);
        int n;
        n = 0;
        while (rom_loaded !== 1'b1 && n < max_cyc) begin
            @(negedge clk_sys);
            n = n + 1;
        end
        chk("rom_loaded_timeout", {63'd0, rom_loaded}, 64'd1);
    endtask

    function automatic logic [15:0] bmask(input logic [1:0] ds, input logic [15:0] d);
        return d & {{8{ds[1]}}, {8{ds[0]}}};
    endfunction

    initial begin
        logic [40:0] e;
        logic        req0;

        vec[0] = '{25'h0000000, 8'h11, 23'h0, 2'b01, 16'h1111};
        vec[1] = '{25'h0000001, 8'h22, 23'h0, 2'b10, 16'h2222};
        vec[2] = '{25'h0000002, 8'h33, 23'h1, 2'b01, 16'h3333};
        vec[3] = '{25'h0000003, 8'h44, 23'h1, 2'b10, 16'h4444};
        vec[4] = '{25'h0000010, 8'h50, 23'h8, 2'b01, 16'h5050};
        vec[5] = '{25'h0000011, 8'h51, 23'h8, 2'b10, 16'h5151};
        vec[6] = '{25'h0000012, 8'h52, 23'h9, 2'b01, 16'h5252};
        vec[7] = '{25'h0000013, 8'h53, 23'h9, 2'b10, 16'h5353};

        reset_n     = 1'b0;
        ioctl_downl = 1'b0;
        ioctl_wr    = 1'b0;
        ioctl_addr  = 25'd0;
        ioctl_dout  = 8'd0;

        // Reset with port_ack=1
        repeat (3) @(negedge clk_sys);
        chk("rst_req",        {63'd0, port_req},   64'd1);
        chk("rst_rom_loaded", {63'd0, rom_loaded}, 64'd0);
        chk("rst_wait",       {63'd0, ioctl_wait}, 64'd0);
        chk("rst_we",         {63'd0, port_we},    64'd0);
        chk("rst_overflow",   {63'd0, overflow},   64'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        chk("rst_no_req", 64'(cap.size()), 64'd0);
        ack_auto = 1'b1;

`ifdef DL_WORD_PACK_EN
        // Word packing: AA@0, BB@1 merge; CC@2 flushed at end of download
        ioctl_downl = 1'b1;
        repeat (2) @(negedge clk_sys);
        wr_byte(25'd0, 8'hAA, 1);
        wr_byte(25'd1, 8'hBB, 1);
        wr_byte(25'd2, 8'hCC, 1);
        @(negedge clk_sys);
        ioctl_downl = 1'b0;
        wait_loaded(300);
        chk("pk_count", 64'(cap.size()), 64'd2);
        e = cap[0];
        chk("pk0_a",  64'(e[40:18]), 64'h0);
        chk("pk0_ds", 64'(e[17:16]), 64'h3);
        chk("pk0_d",  64'(e[15:0]),  64'hBBAA);
        e = cap[1];
        chk("pk1_a",  64'(e[40:18]), 64'h1);
        chk("pk1_ds", 64'(e[17:16]), 64'h1);
        chk("pk1_d",  64'(bmask(e[17:16], e[15:0])), 64'h00CC);
        chk("pk_we_idle", {63'd0, port_we}, 64'd0);
`else
        // Four-byte download, table-checked requests
        ioctl_downl = 1'b1;
        repeat (2) @(negedge clk_sys);
        for (int i = 0; i < 4; i++) begin
            wr_byte(vec[i].addr, vec[i].data, 1);
        end
        @(negedge clk_sys);
        ioctl_downl = 1'b0;
        @(negedge clk_sys);
        chk("t1_not_loaded_yet", {63'd0, rom_loaded}, 64'd0);
        wait_loaded(300);
        chk("t1_count",   64'(cap.size()), 64'd4);
        chk("t1_we_idle", {63'd0, port_we}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            e = cap[i];
            chk($sformatf("t1_a%0d", i),  64'(e[40:18]), 64'(vec[i].ea));
            chk($sformatf("t1_ds%0d", i), 64'(e[17:16]), 64'(vec[i].eds));
            chk($sformatf("t1_d%0d", i),  64'(e[15:0]),  64'(vec[i].ed));
        end

        // New download clears rom_loaded; wr held 5 cycles gives one request, 2-cycle latency
        ioctl_downl = 1'b1;
        repeat (2) @(negedge clk_sys);
        chk("t2_loaded_clr", {63'd0, rom_loaded}, 64'd0);
        cap.delete();
        @(negedge clk_sys);
        ioctl_addr = 25'd5;
        ioctl_dout = 8'h77;
        ioctl_wr   = 1'b1;
        req0       = port_req;
        @(negedge clk_sys);
        chk("t2_lat_early", {63'd0, port_req}, {63'd0, req0});
        @(negedge clk_sys);
        chk("t2_lat_toggle", {63'd0, port_req}, {63'd0, ~req0});
        repeat (3) @(negedge clk_sys);
        ioctl_wr = 1'b0;
        repeat (20) @(negedge clk_sys);
        chk("t2_count", 64'(cap.size()), 64'd1);
        chk("t2_entry", 64'(cap[0]), 64'({23'h2, 2'b10, 16'h7777}));

        // Ack withheld: back-pressure, overflow, then exactly 4 writes
        ack_auto = 1'b0;
        cap.delete();
        wr_byte(vec[4].addr, vec[4].data, 1);
        wr_byte(vec[5].addr, vec[5].data, 1);
        @(negedge clk_sys);
        chk("t3_wait_cnt2", {63'd0, ioctl_wait}, 64'd0);
        wr_byte(vec[6].addr, vec[6].data, 1);
        @(negedge clk_sys);
        chk("t3_wait_cnt3", {63'd0, ioctl_wait}, 64'd1);
        wr_byte(vec[7].addr, vec[7].data, 1);
        chk("t3_no_ovf_yet", {63'd0, overflow}, 64'd0);
        wr_byte(25'h0000014, 8'h54, 1);
        wr_byte(25'h0000015, 8'h55, 1);
        @(negedge clk_sys);
        chk("t3_overflow", {63'd0, overflow}, 64'd1);
        chk("t3_one_issued", 64'(cap.size()), 64'd1);
        ack_auto = 1'b1;
        repeat (60) @(negedge clk_sys);
        chk("t3_count", 64'(cap.size()), 64'd4);
        chk("t3_wait_rel", {63'd0, ioctl_wait}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            e = cap[i];
            chk($sformatf("t3_a%0d", i),  64'(e[40:18]), 64'(vec[4 + i].ea));
            chk($sformatf("t3_ds%0d", i), 64'(e[17:16]), 64'(vec[4 + i].eds));
            chk($sformatf("t3_d%0d", i),  64'(e[15:0]),  64'(vec[4 + i].ed));
        end

        // Reset while a request is outstanding with 2 entries queued, then a stray ack
        ack_auto = 1'b0;
        cap.delete();
        wr_byte(25'h0000020, 8'h60, 1);
        wr_byte(25'h0000021, 8'h61, 1);
        @(negedge clk_sys);
        chk("t4_outstanding", 64'(cap.size()), 64'd1);
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        chk("t4_we_clr",  {63'd0, port_we},  64'd0);
        chk("t4_ovf_clr", {63'd0, overflow}, 64'd0);
        chk("t4_a_clr",   64'(port_a),       64'd0);
        stray_cnt = stray_cnt + 1;
        repeat (10) @(negedge clk_sys);
        chk("t4_stray_we",    {63'd0, port_we}, 64'd0);
        chk("t4_stray_issue", 64'(cap.size()),  64'd1);
        chk("t4_realigned",   {63'd0, port_req}, {63'd0, port_ack});
        ack_auto = 1'b1;
        wr_byte(25'h0000031, 8'h99, 1);
        repeat (20) @(negedge clk_sys);
        chk("t4_after_count", 64'(cap.size()), 64'd2);
        chk("t4_after_entry", 64'(cap[1]), 64'({23'h18, 2'b10, 16'h9999}));
        ioctl_downl = 1'b0;
        wait_loaded(100);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
